// File: rtl/spi_bitrev_pkg.sv
// Shared types and helpers for the bit-reversing SPI test slave.
// Holds the FSM state encoding, SPI-mode edge selection and the bit-reverse helper.
package spi_bitrev_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    XMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int MAX_DATA_W = 32;
  localparam int IDX_W      = $clog2(MAX_DATA_W);

  // Data is sampled on the rising sck edge when CPOL==CPHA, otherwise on the falling edge.
  function automatic bit sample_on_rise(input bit cpol, input bit cpha);
    return cpol == cpha;
  endfunction

  function automatic bit drive_on_rise(input bit cpol, input bit cpha);
    return cpol != cpha;
  endfunction

  // Reverses the low 'width' bits of 'word'; bits above 'width' come back as zero.
  function automatic logic [MAX_DATA_W-1:0] bit_reverse(input logic [MAX_DATA_W-1:0] word,
                                                        input int width);
    logic [MAX_DATA_W-1:0] rev;
    rev = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) begin
        rev[IDX_W'(width - 1 - i)] = word[IDX_W'(i)];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/spi_bitrev_if.sv
// SPI bus lines between a master and the bit-reversing slave.
interface spi_bitrev_if;
  logic sck;
  logic ss_n;
  logic mosi;
  logic miso;

  modport slave  (input sck, input ss_n, input mosi, output miso);
  modport master (output sck, output ss_n, output mosi, input miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, plus a history flop
// that turns the synced level into single-clock rise/fall pulses.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   hist_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = async_in;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Clearing to 0 means a line already low at reset release produces no fall edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= '0;
      hist_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      hist_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~hist_reg;
  assign fall  = ~level & hist_reg;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave that receives one DATA_W-bit word and returns it bit-reversed in
// the same ss_n frame. Everything runs on the system clock; SPI lines are oversampled.
module spi_bitrev_slave
  import spi_bitrev_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  spi_bitrev_if.slave       spi,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              done
);

  localparam int CNT_W       = $clog2(DATA_W + 1);
  localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam bit DRIVE_RISE  = drive_on_rise(CPOL, CPHA);
  localparam int SCK_I       = 0;
  localparam int SS_I        = 1;
  localparam int MOSI_I      = 2;

  logic [2:0] async_vec;
  logic [2:0] lvl;
  logic [2:0] rise_v;
  logic [2:0] fall_v;

  assign async_vec = {spi.mosi, spi.ss_n, spi.sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (async_vec[gi]),
        .level    (lvl[gi]),
        .rise     (rise_v[gi]),
        .fall     (fall_v[gi])
      );
    end
  endgenerate

  logic sample_evt;
  logic drive_evt;
  logic ss_fall;
  logic ss_rise;
  logic mosi_s;
  logic unused_sync;

  assign sample_evt  = SAMPLE_RISE ? rise_v[SCK_I] : fall_v[SCK_I];
  assign drive_evt   = DRIVE_RISE  ? rise_v[SCK_I] : fall_v[SCK_I];
  assign ss_fall     = fall_v[SS_I];
  assign ss_rise     = rise_v[SS_I];
  assign mosi_s      = lvl[MOSI_I];
  assign unused_sync = &{1'b0, lvl[SCK_I], lvl[SS_I], rise_v[MOSI_I], fall_v[MOSI_I]};

  state_t            state_reg,    state_next;
  logic [CNT_W-1:0]  bit_cnt_reg,  bit_cnt_next;
  logic [DATA_W-1:0] rx_sr_reg,    rx_sr_next;
  logic [DATA_W-1:0] tx_sr_reg,    tx_sr_next;
  logic [DATA_W-1:0] rx_data_reg,  rx_data_next;
  logic              miso_reg,     miso_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              done_reg,     done_next;

  logic [DATA_W-1:0] new_word;
  logic [DATA_W-1:0] rev_word;

  assign new_word = {rx_sr_reg[DATA_W-2:0], mosi_s};
  assign rev_word = DATA_W'(bit_reverse(MAX_DATA_W'(new_word), DATA_W));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      rx_sr_reg    <= '0;
      tx_sr_reg    <= '0;
      rx_data_reg  <= '0;
      miso_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_sr_reg    <= rx_sr_next;
      tx_sr_reg    <= tx_sr_next;
      rx_data_reg  <= rx_data_next;
      miso_reg     <= miso_next;
      rx_valid_reg <= rx_valid_next;
      done_reg     <= done_next;
    end
  end

  // ss_n deassertion is tested before any sck edge so it always wins.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_sr_next    = rx_sr_reg;
    tx_sr_next    = tx_sr_reg;
    rx_data_next  = rx_data_reg;
    miso_next     = miso_reg;
    rx_valid_next = 1'b0;
    done_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        miso_next    = 1'b0;
        bit_cnt_next = '0;
        if (ss_fall) begin
          state_next = RECV;
        end
      end

      RECV: begin
        miso_next = 1'b0;
        if (ss_rise) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else if (sample_evt) begin
          rx_sr_next = new_word;
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            rx_data_next  = new_word;
            rx_valid_next = 1'b1;
            tx_sr_next    = rev_word;
            bit_cnt_next  = '0;
            state_next    = XMIT;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      XMIT: begin
        if (ss_rise) begin
          state_next   = IDLE;
          miso_next    = 1'b0;
          bit_cnt_next = '0;
        end else if (drive_evt) begin
          miso_next  = tx_sr_reg[DATA_W-1];
          tx_sr_next = {tx_sr_reg[DATA_W-2:0], 1'b0};
        end else if (sample_evt) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      DONE: begin
        if (ss_rise) begin
          state_next   = IDLE;
          miso_next    = 1'b0;
          bit_cnt_next = '0;
        end else if (drive_evt) begin
          miso_next = 1'b0;
        end
      end

      default: begin
        state_next   = IDLE;
        miso_next    = 1'b0;
        bit_cnt_next = '0;
      end
    endcase
  end

  assign spi.miso = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench for spi_bitrev_slave: four instances (modes 0/3/1 at 8 bits, mode 0 at 16 bits)
// share one sck/mosi master; each frame's results are compared against a bit-reverse model.
module tb_spi_bitrev_slave;

  localparam int H = 8;  // sck half-period in system clocks

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       sck_base = 1'b0;
  logic       mosi     = 1'b0;
  logic [3:0] ss_n     = 4'hF;

  always #5 clock = ~clock;

  spi_bitrev_if bus0 ();
  spi_bitrev_if bus1 ();
  spi_bitrev_if bus2 ();
  spi_bitrev_if bus3 ();

  // sck_base rising is always the leading edge; CPOL=1 instances see it inverted.
  assign bus0.sck  = sck_base;
  assign bus1.sck  = ~sck_base;
  assign bus2.sck  = sck_base;
  assign bus3.sck  = sck_base;
  assign bus0.ss_n = ss_n[0];
  assign bus1.ss_n = ss_n[1];
  assign bus2.ss_n = ss_n[2];
  assign bus3.ss_n = ss_n[3];
  assign bus0.mosi = mosi;
  assign bus1.mosi = mosi;
  assign bus2.mosi = mosi;
  assign bus3.mosi = mosi;

  logic [7:0]  rx0, rx1, rx2;
  logic [15:0] rx3;
  logic [3:0]  rxv, dn, miso;
  logic [31:0] rxd [4];

  assign rxd[0] = {24'd0, rx0};
  assign rxd[1] = {24'd0, rx1};
  assign rxd[2] = {24'd0, rx2};
  assign rxd[3] = {16'd0, rx3};
  assign miso   = {bus3.miso, bus2.miso, bus1.miso, bus0.miso};

  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_m0 (
    .clock(clock), .reset(reset), .spi(bus0), .rx_data(rx0), .rx_valid(rxv[0]), .done(dn[0]));
  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_m3 (
    .clock(clock), .reset(reset), .spi(bus1), .rx_data(rx1), .rx_valid(rxv[1]), .done(dn[1]));
  spi_bitrev_slave #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u_m1 (
    .clock(clock), .reset(reset), .spi(bus2), .rx_data(rx2), .rx_valid(rxv[2]), .done(dn[2]));
  spi_bitrev_slave #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_w16 (
    .clock(clock), .reset(reset), .spi(bus3), .rx_data(rx3), .rx_valid(rxv[3]), .done(dn[3]));

  int w_of    [4] = '{8, 8, 8, 16};
  int cpha_of [4] = '{0, 1, 1, 0};

  int          rxv_cnt  [4] = '{0, 0, 0, 0};
  int          done_cnt [4] = '{0, 0, 0, 0};
  logic [31:0] rx_cap   [4] = '{0, 0, 0, 0};
  logic [31:0] last_word[4] = '{0, 0, 0, 0};

  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (rxv[k]) begin
        rxv_cnt[k] <= rxv_cnt[k] + 1;
        rx_cap[k]  <= rxd[k];
      end
      if (dn[k]) done_cnt[k] <= done_cnt[k] + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference: returned word is the sent word with its DATA_W bits mirrored.
  function automatic logic [31:0] ref_rev(input logic [31:0] word, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (((word >> i) & 32'd1) != 32'd0) r = r | (32'd1 << (w - 1 - i));
    end
    return r;
  endfunction

  // Master: selects slave k, sends word MSB-first, then clocks back w bits.
  // nbits < 0 runs the full 2*w sck cycles; rst_bit >= 0 pulses reset before that XMIT bit.
  task automatic frame(input int k, input logic [31:0] word, input int nbits,
                       input int rst_bit, output logic [31:0] got);
    int w, lim;
    logic [31:0] sh;
    w   = w_of[k];
    lim = (nbits < 0) ? 2 * w : nbits;
    sh  = word << (32 - w);
    got = '0;
    ss_n[k] = 1'b0;
    tick(H);
    for (int i = 0; i < lim; i++) begin
      if (rst_bit >= 0 && i == w + rst_bit) begin
        reset = 1'b1;
        tick(1);
        check("rst_miso", 32'(miso[k]), 32'd0);
        check("rst_rx_data", rxd[k], 32'd0);
        check("rst_rx_valid", 32'(rxv[k]), 32'd0);
        check("rst_done", 32'(dn[k]), 32'd0);
        reset = 1'b0;
      end
      if (cpha_of[k] == 0) begin
        if (i < w) begin mosi = sh[31]; sh = sh << 1; end
        tick(H);
        if (i >= w) got = {got[30:0], miso[k]};
        sck_base = 1'b1;
        tick(H);
        sck_base = 1'b0;
      end else begin
        sck_base = 1'b1;
        if (i < w) begin mosi = sh[31]; sh = sh << 1; end
        tick(H);
        if (i >= w) got = {got[30:0], miso[k]};
        sck_base = 1'b0;
        tick(H);
      end
    end
    tick(H);
  endtask

  task automatic end_frame(input int k);
    ss_n[k] = 1'b1;
    tick(2 * H);
  endtask

  task automatic run_vec(input int k, input logic [31:0] word, input logic [31:0] exp_ret,
                         input int pulses);
    int rxv0, d0;
    logic [31:0] got;
    rxv0 = rxv_cnt[k];
    d0   = done_cnt[k];
    frame(k, word, -1, -1, got);
    if (pulses > 0) begin
      for (int p = 0; p < pulses; p++) begin
        sck_base = 1'b1; tick(H);
        sck_base = 1'b0; tick(H);
      end
      check("done_state_miso", 32'(miso[k]), 32'd0);
      check("done_state_done_count", 32'(done_cnt[k] - d0), 32'd1);
    end
    end_frame(k);
    check("rx_valid_count", 32'(rxv_cnt[k] - rxv0), 32'd1);
    check("rx_data", rx_cap[k], word);
    check("returned_word", got, exp_ret);
    check("done_count", 32'(done_cnt[k] - d0), 32'd1);
    check("miso_after_frame", 32'(miso[k]), 32'd0);
    last_word[k] = word;
    $display("frame inst%0d sent 0x%0h returned 0x%0h expected 0x%0h", k, word, got, exp_ret);
  endtask

  typedef struct {
    int          k;
    logic [31:0] word;
    logic [31:0] exp_ret;
    int          pulses;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          rxv0, d0, k, w;
    logic [31:0] got, word, mask;

    vecs[0] = '{0, 32'hB4,   32'h2D,   3};
    vecs[1] = '{0, 32'h01,   32'h80,   0};
    vecs[2] = '{0, 32'hF0,   32'h0F,   0};
    vecs[3] = '{0, 32'h0F,   32'hF0,   0};
    vecs[4] = '{1, 32'hA5,   32'hA5,   0};
    vecs[5] = '{2, 32'h03,   32'hC0,   0};
    vecs[6] = '{3, 32'h1234, 32'h2C48, 0};

    tick(5);
    for (int i = 0; i < 4; i++) begin
      check("reset_miso", 32'(miso[i]), 32'd0);
      check("reset_rx_data", rxd[i], 32'd0);
      check("reset_rx_valid", 32'(rxv[i]), 32'd0);
      check("reset_done", 32'(dn[i]), 32'd0);
    end
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].k, vecs[i].word, vecs[i].exp_ret, vecs[i].pulses);
    end

    // Abort after 5 bits: nothing reported, previous word retained.
    rxv0 = rxv_cnt[0];
    d0   = done_cnt[0];
    frame(0, 32'hFF, 5, -1, got);
    end_frame(0);
    check("abort_rx_valid", 32'(rxv_cnt[0] - rxv0), 32'd0);
    check("abort_rx_data", rxd[0], last_word[0]);
    check("abort_miso", 32'(miso[0]), 32'd0);
    check("abort_done", 32'(done_cnt[0] - d0), 32'd0);
    $display("abort inst0 after 5 bits, rx_data 0x%0h", rxd[0]);
    run_vec(0, 32'h80, 32'h01, 0);

    for (int n = 0; n < 16; n++) begin
      k    = int'($urandom_range(0, 3));
      w    = w_of[k];
      mask = (32'd1 << w) - 32'd1;
      word = $urandom() & mask;
      run_vec(k, word, ref_rev(word, w), 0);
    end

    // Reset during XMIT bit 3; the still-selected frame must be ignored afterwards.
    rxv0 = rxv_cnt[0];
    d0   = done_cnt[0];
    frame(0, 32'h5A, -1, 3, got);
    end_frame(0);
    check("rst_frame_rx_valid", 32'(rxv_cnt[0] - rxv0), 32'd1);
    check("rst_frame_done", 32'(done_cnt[0] - d0), 32'd0);
    check("rst_frame_miso", 32'(miso[0]), 32'd0);
    $display("reset mid-frame inst0, done pulses %0d", done_cnt[0] - d0);
    run_vec(0, 32'hC3, 32'hC3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_bitrev_slave.md
Name: spi_bitrev_slave

Overview:
- SPI slave test peripheral on the SoC SPI bus, next generation of the bit-reversal device.
- Receives one DATA_W-bit word from the master, then returns it bit-reversed in the same ss_n frame.
- Runs entirely in the system clock domain. sck, ss_n and mosi are oversampled through synchronisers.
- Generalised in word width and SPI mode (CPOL/CPHA). Adds abort on early ss_n deassert, a completion pulse, and a debug view of the received word.

Parameters:
- DATA_W, 8: word width in bits, 2..32.
- CPOL, 0: sck idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: flip-flop stages per synchroniser, >= 2.

Ports:
- clock  in  1  system clock; all state is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from master (asynchronous).
- ss_n  in  1  slave select, active-low (asynchronous).
- mosi  in  1  master-out data (asynchronous).
- miso  out  1  slave-out data, registered.
- rx_data  out  DATA_W  last completely received word.
- rx_valid  out  1  one-clock pulse when rx_data updates.
- done  out  1  one-clock pulse when the reversed word has been fully sent.

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, done=0, state=IDLE, counters=0, shift registers=0.
- Inputs pass through SYNC_STAGES flops, then one history flop for edge detection.
  - Input-to-event latency: SYNC_STAGES+1 clocks.
  - Legal operation requires an sck half-period >= SYNC_STAGES+3 clocks.
- Sample edge is the rising edge of sck when CPOL==CPHA, otherwise the falling edge. Drive edge is the opposite edge.
- States:
  - IDLE: miso=0; edges ignored. Synced ss_n falling -> RECV, bit_cnt=0.
  - RECV:
    - Each sample edge: rx_sr <= {rx_sr[DATA_W-2:0], mosi_s}; bit_cnt++.
    - On the DATA_W-th sample: rx_data <= new word; rx_valid=1 for one clock; tx_sr <= bit-reverse(new word), so tx_sr[DATA_W-1] = first received bit. Then bit_cnt=0 and -> XMIT.
    - CPHA=0: miso is don't-care during RECV, driven 0.
  - XMIT:
    - Each drive edge: miso <= tx_sr[DATA_W-1]; tx_sr <= tx_sr << 1. The first drive edge after entry presents the first bit.
    - Each sample edge: bit_cnt++. On the DATA_W-th: done=1 for one clock -> DONE.
  - DONE: miso <= 0 at the next drive edge; further sck edges ignored; synced ss_n rising -> IDLE.
- Output is MSB-first on the wire: the word is returned reversed relative to how it was sent.
- Abort: synced ss_n rising in RECV or XMIT -> IDLE.
  - Next clock: miso=0, counters=0.
  - No rx_valid and no done.
  - rx_data keeps its previous value.
- Simultaneous events: ss_n deassert wins over an sck edge in the same clock.
- A sample and a drive edge cannot coincide by construction.
- Reset mid-frame: immediate return to reset values. A new frame needs a fresh ss_n falling edge, so a frame already selected at reset release is ignored until ss_n cycles.
- bit_cnt width: $clog2(DATA_W+1). Wraps only through the explicit clears above.

Decomposition:
- Package spi_bitrev_pkg holds:
  - the state enum {IDLE, RECV, XMIT, DONE};
  - localparams deriving sample/drive polarity from CPOL/CPHA;
  - a bit-reverse function parameterised on width.
- Sub-module spi_sync_edge (parameter SYNC_STAGES) is instantiated three times. It outputs the synced level plus rise/fall pulses.
- The FSM and shift registers stay in spi_bitrev_slave.

Test Plan:
- Mode 0, DATA_W=8, send 0xB4 then 8 dummy clocks -> rx_valid pulse with rx_data=0xB4; miso stream 0x2D MSB-first; done pulse; miso=0 after.
- Mode 0, send 0x01 -> returned 0x80. Two back-to-back frames 0xF0 then 0x0F (ss_n high between) -> 0x0F, then 0xF0.
- Mode 3 (CPOL=1,CPHA=1), send 0xA5 -> returned 0xA5. Mode 1, send 0x03 -> returned 0xC0.
- DATA_W=16, mode 0, send 0x1234 -> rx_data=0x1234; returned 0x2C48.
- Abort: ss_n high after 5 bits of 0xFF -> no rx_valid, rx_data unchanged, miso=0. The next full frame 0x80 returns 0x01.
- Reset asserted during XMIT bit 3 -> all outputs 0 the next clock. Extra sck pulses while in DONE -> no miso change and no second done.
